sev_seg_scanner: RTL

- Downstream consumer in the seven-segment controller: time-multiplexes a packed hex value onto a common-anode multi-digit display.
- Internal prescale timer sets per-digit drive time; a blanking interval between digits suppresses ghosting.
- Display inputs are captured into shadow registers at frame boundaries only, so a value change never tears mid-frame.
- Drives the board's active-low anode and cathode pins directly.

---
 rtl/sev_seg_scanner.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sev_seg_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sev_seg_scanner: blanked, tear-free multiplexed scan of a packed hex value  |
// | onto an active-low common-anode display.                          rev 1.0  |
// +----------------------------------------------------------------------------+
module sev_seg_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int DRIVE_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_done_o
);

  localparam int MAX_CYCLES = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES) + 1;
  localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] DRIVE_LAST = TW'(DRIVE_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]   shadow_en_q, shadow_en_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;
  logic                    capture;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    frame_done_d = 1'b0;
    capture      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_BLANK;
          idx_d   = '0;
          timer_d = '0;
          capture = 1'b1;
        end
      end
      ST_BLANK: begin
        if (!en) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          timer_d = '0;
        end else if (timer_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DRIVE: begin
        if (!en) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          timer_d = '0;
        end else if (timer_q == DRIVE_LAST) begin
          state_d = ST_BLANK;
          timer_d = '0;
          if (idx_q == LAST_IDX) begin
            // Frame boundary: the only point besides IDLE exit where inputs are sampled.
            idx_d        = '0;
            frame_done_d = 1'b1;
            capture      = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        timer_d = '0;
      end
    endcase

    shadow_val_d = capture ? value_i    : shadow_val_q;
    shadow_dp_d  = capture ? dp_i       : shadow_dp_q;
    shadow_en_d  = capture ? digit_en_i : shadow_en_q;

    // Pins are registered from the next state so they change on the same edge as the FSM.
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_d == ST_DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IW'(i)) begin
          an_d[i] = ~shadow_en_q[i];
          seg_d   = decode(shadow_val_q[4*i +: 4]);
          dp_d    = ~shadow_dp_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      timer_q      <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      shadow_en_q  <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_en_q  <= shadow_en_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire
